// File: rtl/opc5ls_timer_intc.sv
// opc5ls bus responder: programmable prescaled down-counter with an
// active-low interrupt request. Four registers at BASE..BASE+3:
// CTRL, RELOAD, COUNT, STATUS.
module opc5ls_timer_intc #(
   parameter logic [15:0] BASE = 16'hFF00,
   parameter int          PSW  = 8
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic [15:0] address,
   input  logic [15:0] din,
   input  logic        rnw,
   output logic [15:0] dout,
   output logic        sel,
   output logic        int_b
);

   localparam logic [1:0] IDX_CTRL   = 2'd0;
   localparam logic [1:0] IDX_RELOAD = 2'd1;
   localparam logic [1:0] IDX_COUNT  = 2'd2;
   localparam logic [1:0] IDX_STATUS = 2'd3;

   // CTRL fields
   logic           en_q,       en_d;
   logic           ie_q,       ie_d;
   logic           auto_q,     auto_d;
   logic [PSW-1:0] prescale_q, prescale_d;
   // data registers
   logic [15:0]    reload_q,   reload_d;
   logic [15:0]    count_q,    count_d;
   // STATUS fields
   logic           expired_q,  expired_d;
   logic           overrun_q,  overrun_d;
   // prescaler and interrupt output
   logic [PSW-1:0] pcnt_q,     pcnt_d;
   logic           int_b_q,    int_b_d;

   logic       wr_en;
   logic       wr_ctrl;
   logic       wr_reload;
   logic       wr_count;
   logic       wr_status;
   logic       tick;
   logic       expiry;

   // Address decode and write strobes; the window is word aligned so the
   // low two address bits select the register.
   assign sel       = (address[15:2] == BASE[15:2]);
   assign wr_en     = sel & ~rnw;
   assign wr_ctrl   = wr_en & (address[1:0] == IDX_CTRL);
   assign wr_reload = wr_en & (address[1:0] == IDX_RELOAD);
   assign wr_count  = wr_en & (address[1:0] == IDX_COUNT);
   assign wr_status = wr_en & (address[1:0] == IDX_STATUS);

   // A tick is dropped when software turns the timer off on the same edge,
   // so disabling is always clean even if it races with the prescaler.
   assign tick   = en_q & (pcnt_q == prescale_q) & ~(wr_ctrl & ~din[0]);
   assign expiry = tick & (count_q == 16'h0000);

   // Prescaler, countdown, reload and software writes to CTRL/RELOAD/COUNT.
   always_comb begin
      en_d       = en_q;
      ie_d       = ie_q;
      auto_d     = auto_q;
      prescale_d = prescale_q;
      reload_d   = reload_q;
      count_d    = count_q;

      // prescaler restarts on every tick and idles at zero while disabled
      if (!en_q || tick) begin
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + PSW'(1);
      end

      // countdown; expiry uses the RELOAD value from before any same-cycle write
      if (tick) begin
         if (count_q != 16'h0000) begin
            count_d = count_q - 16'd1;
         end else if (auto_q) begin
            count_d = reload_q;
         end else begin
            en_d = 1'b0;
         end
      end

      // software writes take precedence over the countdown for the same field
      if (wr_ctrl) begin
         en_d       = din[0];
         ie_d       = din[1];
         auto_d     = din[2];
         prescale_d = din[4+PSW-1:4];
      end
      if (wr_reload) begin
         reload_d = din;
      end
      if (wr_count) begin
         count_d = din;
      end

      // whenever the timer ends up disabled the prescaler is parked at zero,
      // which also gives a full PRESCALE+1 period after re-enabling
      if (!en_d) begin
         pcnt_d = '0;
      end
   end

   // STATUS flags: write-1-to-clear first, then hardware set, so a
   // coinciding expiry is never lost.
   always_comb begin
      expired_d = expired_q;
      overrun_d = overrun_q;
      if (wr_status) begin
         if (din[0]) begin
            expired_d = 1'b0;
         end
         if (din[1]) begin
            overrun_d = 1'b0;
         end
      end
      if (expiry) begin
         expired_d = 1'b1;
         if (expired_q) begin
            overrun_d = 1'b1;
         end
      end
      int_b_d = ~(expired_d & ie_d);
   end

   // Read mux: side-effect free, zero outside the window.
   always_comb begin
      dout = 16'h0000;
      if (sel) begin
         case (address[1:0])
            IDX_CTRL: begin
               dout[0]           = en_q;
               dout[1]           = ie_q;
               dout[2]           = auto_q;
               dout[4+PSW-1:4]   = prescale_q;
            end
            IDX_RELOAD: dout = reload_q;
            IDX_COUNT:  dout = count_q;
            default: begin
               dout[0] = expired_q;
               dout[1] = overrun_q;
            end
         endcase
      end
   end

   // State registers; reset beats any write or tick on the same edge.
   always_ff @(posedge clk) begin
      if (!reset_b) begin
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         auto_q     <= 1'b0;
         prescale_q <= '0;
         reload_q   <= 16'h0000;
         count_q    <= 16'h0000;
         expired_q  <= 1'b0;
         overrun_q  <= 1'b0;
         pcnt_q     <= '0;
         int_b_q    <= 1'b1;
      end else begin
         en_q       <= en_d;
         ie_q       <= ie_d;
         auto_q     <= auto_d;
         prescale_q <= prescale_d;
         reload_q   <= reload_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         overrun_q  <= overrun_d;
         pcnt_q     <= pcnt_d;
         int_b_q    <= int_b_d;
      end
   end

   assign int_b = int_b_q;

endmodule

// File: tb/tb_opc5ls_timer_intc.sv
// Bench for opc5ls_timer_intc: directed scenarios followed by random bus
// traffic, all checked against a cycle-level behavioural model of the timer.
module tb_opc5ls_timer_intc;

   localparam logic [15:0] BASE    = 16'hFF00;
   localparam logic [13:0] BASE_HI = BASE[15:2];

   logic        clk;
   logic        reset_b;
   logic [15:0] address;
   logic [15:0] din;
   logic        rnw;
   logic [15:0] dout;
   logic        sel;
   logic        int_b;

   int n_checks = 0;
   int n_errors = 0;

   opc5ls_timer_intc #(.BASE(BASE), .PSW(8)) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .address (address),
      .din     (din),
      .rnw     (rnw),
      .dout    (dout),
      .sel     (sel),
      .int_b   (int_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // reference model state (m_*) and pending next state (n_*)
   logic        m_en, m_ie, m_auto, m_exp, m_ovr, m_intb;
   logic [7:0]  m_ps, m_pcnt;
   logic [15:0] m_reload, m_count;
   logic        n_en, n_ie, n_auto, n_exp, n_ovr, n_intb;
   logic [7:0]  n_ps, n_pcnt;
   logic [15:0] n_reload, n_count;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model_read(input logic [1:0] idx);
      logic [15:0] v;
      v = 16'h0000;
      case (idx)
         2'd0: v = {4'h0, m_ps, 1'b0, m_auto, m_ie, m_en};
         2'd1: v = m_reload;
         2'd2: v = m_count;
         default: v = {14'h0, m_ovr, m_exp};
      endcase
      return v;
   endfunction

   // One clock of timer behaviour as seen by software.
   task automatic model_step(input logic rst_b, input logic [15:0] a,
                             input logic [15:0] d, input logic rd);
      logic       w;
      logic       fire;
      logic [1:0] r;
      n_en = m_en; n_ie = m_ie; n_auto = m_auto; n_ps = m_ps;
      n_reload = m_reload; n_count = m_count; n_exp = m_exp; n_ovr = m_ovr;
      n_pcnt = m_pcnt; n_intb = m_intb;
      if (!rst_b) begin
         n_en = 0; n_ie = 0; n_auto = 0; n_ps = 0; n_reload = 0; n_count = 0;
         n_exp = 0; n_ovr = 0; n_pcnt = 0; n_intb = 1;
         return;
      end
      w    = (a[15:2] == BASE_HI) && !rd;
      r    = a[1:0];
      fire = m_en && (m_pcnt == m_ps) && !(w && r == 2'd0 && !d[0]);
      if (w && r == 2'd3) begin
         if (d[0]) n_exp = 0;
         if (d[1]) n_ovr = 0;
      end
      if (fire) begin
         if (m_count == 0) begin
            if (m_exp) n_ovr = 1;
            n_exp = 1;
            if (m_auto) n_count = m_reload;
            else        n_en = 0;
         end else begin
            n_count = m_count - 16'd1;
         end
      end
      n_pcnt = (fire || !m_en) ? 8'd0 : m_pcnt + 8'd1;
      if (w) begin
         case (r)
            2'd0: begin n_en = d[0]; n_ie = d[1]; n_auto = d[2]; n_ps = d[11:4]; end
            2'd1: n_reload = d;
            2'd2: n_count = d;
            default: ;
         endcase
      end
      if (!n_en) n_pcnt = 0;
      n_intb = !(n_exp && n_ie);
   endtask

   task automatic model_commit();
      m_en = n_en; m_ie = n_ie; m_auto = n_auto; m_ps = n_ps;
      m_reload = n_reload; m_count = n_count; m_exp = n_exp; m_ovr = n_ovr;
      m_pcnt = n_pcnt; m_intb = n_intb;
   endtask

   // One bus transaction = one clock. Combinational read data is sampled
   // before the edge, int_b just after it.
   task automatic bus(input logic [15:0] a, input logic [15:0] d, input logic rd,
                      output logic [15:0] rdata);
      logic exp_sel;
      address = a; din = d; rnw = rd;
      #1;
      exp_sel = (a[15:2] == BASE_HI);
      check("sel", {31'h0, sel}, {31'h0, exp_sel});
      if (reset_b)
         check("dout", {16'h0, dout}, {16'h0, (exp_sel ? model_read(a[1:0]) : 16'h0000)});
      rdata = dout;
      if (!rd && reset_b) $display("wr addr=%h data=%h", a, d);
      model_step(reset_b, a, d, rd);
      @(posedge clk);
      #1;
      model_commit();
      check("int_b", {31'h0, int_b}, {31'h0, m_intb});
   endtask

   initial begin
      logic [15:0] rd_v, prev_cnt, a, d;
      logic        prev_ib, found;
      int          first, t, decs, r;
      int          exp_t[$];

      m_en = 0; m_ie = 0; m_auto = 0; m_ps = 0; m_reload = 0; m_count = 0;
      m_exp = 0; m_ovr = 0; m_pcnt = 0; m_intb = 1;
      reset_b = 0; address = 0; din = 0; rnw = 1;

      // reset with a competing CTRL write
      bus(BASE, 16'hFFFF, 0, rd_v);
      bus(BASE, 16'hFFFF, 0, rd_v);
      reset_b = 1;
      bus(16'h0000, 16'h0000, 1, rd_v);
      check("rst_sel0", {31'h0, sel}, 0);
      check("rst_dout0", {16'h0, rd_v}, 0);
      check("rst_intb", {31'h0, int_b}, 1);
      for (int i = 0; i < 4; i++) begin
         bus(BASE + 16'(i), 16'h0000, 1, rd_v);
         check("rst_reg", {16'h0, rd_v}, 0);
      end

      // register access
      bus(BASE + 16'd1, 16'h1234, 0, rd_v);
      bus(BASE, 16'h0056, 0, rd_v);
      bus(BASE + 16'd1, 16'h0000, 1, rd_v);
      check("reload_rb", {16'h0, rd_v}, 32'h1234);
      bus(BASE, 16'h0000, 1, rd_v);
      check("ctrl_rb", {16'h0, rd_v}, 32'h0056);
      bus(BASE + 16'd3, 16'h0000, 0, rd_v);
      bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      check("status_w0", {16'h0, rd_v}, 0);

      // one-shot: COUNT=3, PRESCALE=1 -> expiry 8 edges after enabling write
      bus(BASE + 16'd2, 16'd3, 0, rd_v);
      bus(BASE, 16'h0013, 0, rd_v);
      first = -1;
      for (int k = 1; k <= 20; k++) begin
         bus(BASE + 16'd3, 16'h0000, 1, rd_v);
         if (first < 0 && int_b == 1'b0) first = k;
      end
      check("oneshot_lat", first, 8);
      bus(BASE, 16'h0000, 1, rd_v);
      check("oneshot_ctrl", {16'h0, rd_v}, 32'h0012);
      bus(BASE + 16'd2, 16'h0000, 1, rd_v);
      check("oneshot_count", {16'h0, rd_v}, 0);
      bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      check("oneshot_status", {16'h0, rd_v}, 1);
      bus(BASE + 16'd3, 16'h0001, 0, rd_v);
      check("oneshot_clr", {31'h0, int_b}, 1);

      // periodic: RELOAD=4, PRESCALE=2 -> expiry every 15 cycles
      bus(BASE + 16'd1, 16'd4, 0, rd_v);
      bus(BASE + 16'd2, 16'd4, 0, rd_v);
      bus(BASE, 16'h0027, 0, rd_v);
      for (t = 1; t <= 40; t++) begin
         prev_ib = int_b;
         if (int_b == 1'b0) bus(BASE + 16'd3, 16'h0001, 0, rd_v);
         else               bus(BASE + 16'd3, 16'h0000, 1, rd_v);
         if (prev_ib && !int_b) exp_t.push_back(t);
      end
      check("per_n", exp_t.size(), 2);
      check("per_first", (exp_t.size() > 0) ? exp_t[0] : -1, 15);
      check("per_period", (exp_t.size() > 1) ? exp_t[1] - exp_t[0] : -1, 15);
      for (int k = 0; k < 20; k++) bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      check("per_overrun", {16'h0, rd_v}, 3);

      // collision: clear EXPIRED on the very edge that expires again
      bus(BASE + 16'd3, 16'h0002, 0, rd_v);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (m_en && m_pcnt == m_ps && m_count == 0) found = 1;
         else bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      end
      check("coll_found", {31'h0, found}, 1);
      bus(BASE + 16'd3, 16'h0001, 0, rd_v);
      check("coll_intb", {31'h0, int_b}, 0);
      bus(BASE + 16'd3, 16'h0000, 1, rd_v);
      check("coll_status", {16'h0, rd_v}, 3);

      // decode: neighbours of the window do nothing
      bus(BASE + 16'd4, 16'hFFFF, 0, rd_v);
      check("dec_sel_hi", {31'h0, sel}, 0);
      bus(BASE - 16'd1, 16'hFFFF, 0, rd_v);
      check("dec_sel_lo", {31'h0, sel}, 0);
      bus(BASE, 16'h0000, 1, rd_v);
      check("dec_ctrl", {16'h0, rd_v}, 32'h0027);
      bus(BASE + 16'd1, 16'h0000, 1, rd_v);
      check("dec_reload", {16'h0, rd_v}, 4);
      decs = 0;
      bus(BASE + 16'd2, 16'h0000, 1, prev_cnt);
      for (int k = 0; k < 20; k++) begin
         bus(BASE + 16'd2, 16'h0000, 1, rd_v);
         if (rd_v == prev_cnt - 16'd1) decs++;
         prev_cnt = rd_v;
      end
      check("count_moves", {31'h0, (decs >= 4)}, 1);

      bus(BASE, 16'h0000, 0, rd_v);
      bus(BASE + 16'd3, 16'h0003, 0, rd_v);

      // random traffic
      for (int k = 0; k < 2000; k++) begin
         r = $urandom_range(0, 99);
         if (r < 1) begin
            reset_b = 0;
            bus(BASE, 16'($urandom), 0, rd_v);
            reset_b = 1;
         end else if (r < 60) begin
            bus(BASE + 16'($urandom_range(0, 3)), 16'($urandom), 1, rd_v);
         end else if (r < 70) begin
            a = 16'($urandom);
            if (a[15:2] == BASE_HI) a[8] = ~a[8];
            bus(a, 16'($urandom), (r < 65), rd_v);
         end else begin
            a = BASE + 16'($urandom_range(0, 3));
            d = 16'($urandom);
            case (a[1:0])
               2'd0: begin
                  d[11:4] = 8'($urandom_range(0, 3));
                  d[0]    = ($urandom_range(0, 9) < 7);
               end
               2'd1, 2'd2: if ($urandom_range(0, 9) != 0) d = 16'($urandom_range(0, 12));
               default: ;
            endcase
            bus(a, d, 0, rd_v);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
